// File: rtl/icache_data_array_ctrl_mb_if.sv
// Handshake bundle of the I-cache data-array controller: hit reads, linefill beats,
// linefill completion and the upstream data queue.
interface icache_data_array_ctrl_mb_if #(
   parameter int WAY_NUM     = 4,
   parameter int INDEX_WIDTH = 6,
   parameter int LINE_WIDTH  = 512,
   parameter int BEAT_WIDTH  = 256,
   parameter int TXNID_WIDTH = 8,
   parameter int ENTRY_W     = 3
);
   localparam int WAY_W = $clog2(WAY_NUM);

   logic                   rd_vld;
   logic                   rd_rdy;
   logic [WAY_W-1:0]       rd_way;
   logic [INDEX_WIDTH-1:0] rd_index;
   logic [TXNID_WIDTH-1:0] rd_txnid;

   logic                   fill_vld;
   logic                   fill_rdy;
   logic [BEAT_WIDTH-1:0]  fill_data;
   logic                   fill_last;
   logic [INDEX_WIDTH-1:0] fill_index;
   logic [WAY_W-1:0]       fill_way;
   logic [ENTRY_W-1:0]     fill_entry_idx;
   logic [TXNID_WIDTH-1:0] fill_txnid;
   logic                   fill_fwd;

   logic                   linefill_done;
   logic [ENTRY_W:0]       linefill_ack_entry_idx;

   logic                   up_vld;
   logic                   up_rdy;
   logic [LINE_WIDTH-1:0]  up_data;
   logic [TXNID_WIDTH-1:0] up_txnid;

   modport master (
      output rd_vld, rd_way, rd_index, rd_txnid,
      output fill_vld, fill_data, fill_last, fill_index, fill_way, fill_entry_idx, fill_txnid, fill_fwd,
      output up_rdy,
      input  rd_rdy, fill_rdy, linefill_done, linefill_ack_entry_idx, up_vld, up_data, up_txnid
   );

   modport slave (
      input  rd_vld, rd_way, rd_index, rd_txnid,
      input  fill_vld, fill_data, fill_last, fill_index, fill_way, fill_entry_idx, fill_txnid, fill_fwd,
      input  up_rdy,
      output rd_rdy, fill_rdy, linefill_done, linefill_ack_entry_idx, up_vld, up_data, up_txnid
   );
endinterface

// File: rtl/icache_data_array_ctrl_mb.sv
// I-cache data-array controller: banked line SRAM, multi-beat linefill buffer, read/fill
// arbitration with starvation guard, and a credit-protected upstream output queue.
module icache_data_array_ctrl_mb #(
   parameter int WAY_NUM     = 4,
   parameter int INDEX_WIDTH = 6,
   parameter int LINE_WIDTH  = 512,
   parameter int BANK_NUM    = 2,
   parameter int BEAT_WIDTH  = 256,
   parameter int TXNID_WIDTH = 8,
   parameter int ENTRY_W     = 3,
   parameter int STARVE_MAX  = 4,
   parameter int OUTQ_DEPTH  = 2
) (
   input logic clk,
   input logic rst,
   icache_data_array_ctrl_mb_if.slave bus
);
   localparam int WAY_W  = $clog2(WAY_NUM);
   localparam int BEATS  = LINE_WIDTH / BEAT_WIDTH;
   localparam int BANK_W = LINE_WIDTH / BANK_NUM;
   localparam int ADDR_W = INDEX_WIDTH + WAY_W;
   localparam int SETS   = 1 << ADDR_W;
   localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int QPTR_W = $clog2(OUTQ_DEPTH);
   localparam int QCNT_W = $clog2(OUTQ_DEPTH + 1);
   localparam int CRED_W = QCNT_W + 1;
   localparam int STV_W  = $clog2(STARVE_MAX + 1);

   typedef enum logic {COLLECT = 1'b0, WR_PEND = 1'b1} state_e;

   state_e                                state_q, state_d;
   logic [BCNT_W-1:0]                     beat_q, beat_d;
   logic [BEATS-1:0][BEAT_WIDTH-1:0]      lbuf_q, lbuf_d;
   logic [INDEX_WIDTH-1:0]                f_index_q, f_index_d;
   logic [WAY_W-1:0]                      f_way_q, f_way_d;
   logic [ENTRY_W-1:0]                    f_entry_q, f_entry_d;
   logic [TXNID_WIDTH-1:0]                f_txnid_q, f_txnid_d;
   logic                                  f_fwd_q, f_fwd_d;
   logic [STV_W-1:0]                      starve_q, starve_d;
   logic                                  rd_pend_q, rd_pend_d;
   logic [TXNID_WIDTH-1:0]                rd_tid_q, rd_tid_d;
   logic [OUTQ_DEPTH-1:0][LINE_WIDTH-1:0] q_data_q, q_data_d;
   logic [OUTQ_DEPTH-1:0][TXNID_WIDTH-1:0] q_tid_q, q_tid_d;
   logic [QPTR_W-1:0]                     q_head_q, q_head_d;
   logic [QCNT_W-1:0]                     q_cnt_q, q_cnt_d;

   logic [LINE_WIDTH-1:0]  wr_line, rd_line;
   logic [ADDR_W-1:0]      waddr, raddr;
   logic [CRED_W-1:0]      free;
   logic                   credit_ok, wr_req, rd_req, wgnt, rgnt, pop, pop_stored;
   logic                   in0_vld, in1_vld, s0_vld, s1_vld;
   logic [LINE_WIDTH-1:0]  in0_data, in1_data, s0_data, s1_data;
   logic [TXNID_WIDTH-1:0] in0_tid, in1_tid, s0_tid, s1_tid;
   logic [QPTR_W-1:0]      tail0, tail1;

   function automatic logic [QPTR_W-1:0] qwrap(input int unsigned v);
      return QPTR_W'(v % OUTQ_DEPTH);
   endfunction

   assign wr_line = lbuf_q;
   assign waddr   = {f_index_q, f_way_q};
   assign raddr   = {bus.rd_index, bus.rd_way};

   // A pop only returns credit when the popped entry was already committed (stored or in
   // flight); this keeps the credit path free of any dependence on this cycle's grants.
   always_comb begin
      free = CRED_W'(OUTQ_DEPTH) - CRED_W'(q_cnt_q) - CRED_W'(rd_pend_q)
           + CRED_W'(bus.up_rdy && (q_cnt_q != '0 || rd_pend_q));
      credit_ok = (free != '0);
      wr_req    = (state_q == WR_PEND) && (!f_fwd_q || credit_ok);
      rd_req    = bus.rd_vld && credit_ok && !rst;
      wgnt      = wr_req && !(rd_req && starve_q == STV_W'(STARVE_MAX));
      rgnt      = rd_req && !wgnt;
      starve_d  = starve_q;
      if (rgnt)
         starve_d = '0;
      else if (rd_req && starve_q != STV_W'(STARVE_MAX))
         starve_d = starve_q + 1'b1;
      rd_pend_d = rgnt;
      rd_tid_d  = rgnt ? bus.rd_txnid : rd_tid_q;
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      lbuf_d    = lbuf_q;
      f_index_d = f_index_q;
      f_way_d   = f_way_q;
      f_entry_d = f_entry_q;
      f_txnid_d = f_txnid_q;
      f_fwd_d   = f_fwd_q;
      case (state_q)
         COLLECT: if (bus.fill_vld) begin
            if (beat_q == '0) begin
               lbuf_d    = '0;
               f_index_d = bus.fill_index;
               f_way_d   = bus.fill_way;
               f_entry_d = bus.fill_entry_idx;
               f_txnid_d = bus.fill_txnid;
               f_fwd_d   = bus.fill_fwd;
            end
            lbuf_d[beat_q] = bus.fill_data;
            if (bus.fill_last || beat_q == BCNT_W'(BEATS - 1)) begin
               state_d = WR_PEND;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         WR_PEND: if (wgnt) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
      logic [BANK_W-1:0] mem [SETS];
      logic [BANK_W-1:0] rdat_q;
      always_ff @(posedge clk) begin
         if (wgnt) mem[waddr] <= wr_line[b*BANK_W +: BANK_W];
         if (rgnt) rdat_q <= mem[raddr];
      end
      assign rd_line[b*BANK_W +: BANK_W] = rdat_q;
   end

   // Read data from last cycle's grant enters ahead of a forwarded fill pushed this cycle.
   always_comb begin
      in0_vld = 1'b0; in0_data = '0; in0_tid = '0;
      in1_vld = 1'b0; in1_data = '0; in1_tid = '0;
      if (rd_pend_q) begin
         in0_vld = 1'b1; in0_data = rd_line; in0_tid = rd_tid_q;
         in1_vld = wgnt && f_fwd_q; in1_data = wr_line; in1_tid = f_txnid_q;
      end else begin
         in0_vld = wgnt && f_fwd_q; in0_data = wr_line; in0_tid = f_txnid_q;
      end
   end

   assign bus.up_vld   = (q_cnt_q != '0) || in0_vld;
   assign bus.up_data  = (q_cnt_q != '0) ? q_data_q[q_head_q] : (in0_vld ? in0_data : '0);
   assign bus.up_txnid = (q_cnt_q != '0) ? q_tid_q[q_head_q]  : (in0_vld ? in0_tid  : '0);
   assign pop          = bus.up_vld && bus.up_rdy;
   assign pop_stored   = pop && (q_cnt_q != '0);

   always_comb begin
      q_data_d = q_data_q;
      q_tid_d  = q_tid_q;
      q_head_d = q_head_q;
      if (pop && q_cnt_q == '0) begin
         s0_vld = in1_vld; s0_data = in1_data; s0_tid = in1_tid;
         s1_vld = 1'b0;    s1_data = '0;       s1_tid = '0;
      end else begin
         s0_vld = in0_vld; s0_data = in0_data; s0_tid = in0_tid;
         s1_vld = in1_vld; s1_data = in1_data; s1_tid = in1_tid;
      end
      tail0 = qwrap(int'(q_head_q) + int'(q_cnt_q));
      tail1 = qwrap(int'(tail0) + 1);
      if (s0_vld) begin
         q_data_d[tail0] = s0_data;
         q_tid_d[tail0]  = s0_tid;
      end
      if (s1_vld) begin
         q_data_d[tail1] = s1_data;
         q_tid_d[tail1]  = s1_tid;
      end
      if (pop_stored) q_head_d = qwrap(int'(q_head_q) + 1);
      q_cnt_d = q_cnt_q + QCNT_W'(s0_vld) + QCNT_W'(s1_vld) - QCNT_W'(pop_stored);
   end

   assign bus.fill_rdy               = (state_q == COLLECT) && !rst;
   assign bus.rd_rdy                 = rgnt;
   assign bus.linefill_done          = wgnt;
   assign bus.linefill_ack_entry_idx = wgnt ? {1'b0, f_entry_q} : '1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= COLLECT;
         beat_q    <= '0;
         lbuf_q    <= '0;
         f_index_q <= '0;
         f_way_q   <= '0;
         f_entry_q <= '0;
         f_txnid_q <= '0;
         f_fwd_q   <= 1'b0;
         starve_q  <= '0;
         rd_pend_q <= 1'b0;
         rd_tid_q  <= '0;
         q_data_q  <= '0;
         q_tid_q   <= '0;
         q_head_q  <= '0;
         q_cnt_q   <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         lbuf_q    <= lbuf_d;
         f_index_q <= f_index_d;
         f_way_q   <= f_way_d;
         f_entry_q <= f_entry_d;
         f_txnid_q <= f_txnid_d;
         f_fwd_q   <= f_fwd_d;
         starve_q  <= starve_d;
         rd_pend_q <= rd_pend_d;
         rd_tid_q  <= rd_tid_d;
         q_data_q  <= q_data_d;
         q_tid_q   <= q_tid_d;
         q_head_q  <= q_head_d;
         q_cnt_q   <= q_cnt_d;
      end
   end
endmodule
